// File: rtl/onehot_decoder_pipe_if.sv
// Valid/ready command and decoded-output bus of onehot_decoder_pipe.
interface onehot_decoder_pipe_if #(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_dec;
  logic             out_err;

  // Producer/consumer side: drives commands and output acceptance.
  modport master (
    output in_valid, in_sel, in_mode, out_ready,
    input  in_ready, out_valid, out_dec, out_err
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_sel, in_mode, out_ready,
    output in_ready, out_valid, out_dec, out_err
  );
endinterface

// File: rtl/onehot_decoder_pipe.sv
// Registered select decoder (one-hot / thermometer / active-low one-hot)
// with a valid/ready handshake, 2-entry skid buffer and saturating error count.
module onehot_decoder_pipe #(
  parameter int SEL_W     = 3,
  parameter int N_OUT     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_decoder_pipe_if.slave bus,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_t;

  localparam logic [SEL_W:0] N_OUT_L = N_OUT[SEL_W:0];

  occ_t             state, state_nxt;
  logic [N_OUT-1:0] main_dec, skid_dec, dec_vec;
  logic             main_err, skid_err, dec_err;
  logic             in_xfer, out_xfer;
  logic             load_main, load_skid, move_skid;

  assign bus.in_ready  = (state != OCC_TWO) && !rst;
  assign bus.out_valid = (state != OCC_EMPTY);
  assign bus.out_dec   = main_dec;
  assign bus.out_err   = main_err;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  // Decode the incoming select according to the requested mode.
  always_comb begin
    dec_vec = '0;
    dec_err = 1'b0;
    if (bus.in_mode == 2'b11 || {1'b0, bus.in_sel} >= N_OUT_L) begin
      dec_err = 1'b1;
    end else begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        case (bus.in_mode)
          2'b00:   dec_vec[i] = (i == 32'(bus.in_sel));
          2'b01:   dec_vec[i] = (i <= 32'(bus.in_sel));
          default: dec_vec[i] = (i != 32'(bus.in_sel));
        endcase
      end
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OCC_EMPTY;
    else     state <= state_nxt;
  end

  // Occupancy next-state and storage load controls.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (in_xfer) begin
          state_nxt = OCC_ONE;
          load_main = 1'b1;
        end
      end
      OCC_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_nxt = OCC_TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (out_xfer) begin
          state_nxt = OCC_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  // Main (output) and skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_dec <= '0;
      main_err <= 1'b0;
      skid_dec <= '0;
      skid_err <= 1'b0;
    end else begin
      if (load_main) begin
        main_dec <= dec_vec;
        main_err <= dec_err;
      end else if (move_skid) begin
        main_dec <= skid_dec;
        main_err <= skid_err;
      end
      if (load_skid) begin
        skid_dec <= dec_vec;
        skid_err <= dec_err;
      end
    end
  end

  // Saturating count of errored beats delivered; a clear that coincides
  // with an errored delivery leaves that delivery counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= (out_xfer && main_err) ? ERR_CNT_W'(1) : '0;
    end else if (out_xfer && main_err && err_count != '1) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Scoreboard bench: two decoder instances (8 outputs / 8-bit counter and
// 6 outputs / 2-bit counter) receive identical stimulus.
module tb_onehot_decoder_pipe;

  typedef struct packed {
    logic [7:0] dec;
    logic       err;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_sel = '0;
  logic [1:0] in_mode = '0;
  logic       out_ready = 1'b1;
  logic       clr_err = 1'b0;
  logic       rnd_ready = 1'b0;
  logic [7:0] err_count_a;
  logic [1:0] err_count_b;

  int    errors = 0;
  int    checks = 0;
  beat_t qa[$];
  beat_t qb[$];
  int    cnt_a = 0;
  int    cnt_b = 0;

  always #5 clk = ~clk;

  onehot_decoder_pipe_if #(.SEL_W(3), .N_OUT(8)) ifa ();
  onehot_decoder_pipe_if #(.SEL_W(3), .N_OUT(6)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_sel    = in_sel;
  assign ifa.in_mode   = in_mode;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_sel    = in_sel;
  assign ifb.in_mode   = in_mode;
  assign ifb.out_ready = out_ready;

  onehot_decoder_pipe #(.SEL_W(3), .N_OUT(8), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .clr_err(clr_err), .err_count(err_count_a)
  );
  onehot_decoder_pipe #(.SEL_W(3), .N_OUT(6), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .clr_err(clr_err), .err_count(err_count_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decode from plain arithmetic on the select value.
  function automatic beat_t model(input int sel, input int mode, input int nout);
    beat_t b;
    int v;
    if (mode == 3 || sel >= nout) begin
      b.dec = '0;
      b.err = 1'b1;
      return b;
    end
    case (mode)
      0:       v = 1 << sel;
      1:       v = (2 << sel) - 1;
      default: v = ~(1 << sel) & ((1 << nout) - 1);
    endcase
    b.dec = 8'(v);
    b.err = 1'b0;
    return b;
  endfunction

  function automatic int cnt_next(input int c, input bit clr, input bit xerr, input int maxv);
    if (clr) return xerr ? 1 : 0;
    if (xerr && c < maxv) return c + 1;
    return c;
  endfunction

  // Present one beat and hold it until accepted; expected results are queued at acceptance.
  task automatic send(input int sel, input int mode, input bit lat);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_sel   = 3'(sel);
    in_mode  = 2'(mode);
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (ifa.in_ready) begin
        acc = 1'b1;
        qa.push_back(model(sel, mode, 8));
        qb.push_back(model(sel, mode, 6));
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: got=not accepted expected=accepted sel=%0d mode=%0d", sel, mode);
      in_valid = 1'b0;
    end else if (lat) begin
      chk("a_latency", 32'(ifa.out_valid), 32'd1);
      chk("b_latency", 32'(ifb.out_valid), 32'd1);
    end
  endtask

  // Monitor for instance A.
  always @(negedge clk) begin
    beat_t e;
    bit xerr;
    if (rst) begin
      chk("a_rst_out_valid", 32'(ifa.out_valid), 32'd0);
      chk("a_rst_out_dec", 32'(ifa.out_dec), 32'd0);
      chk("a_rst_out_err", 32'(ifa.out_err), 32'd0);
      chk("a_rst_err_count", 32'(err_count_a), 32'd0);
      chk("a_rst_in_ready", 32'(ifa.in_ready), 32'd0);
      qa.delete();
      cnt_a = 0;
    end else begin
      chk("a_err_count", 32'(err_count_a), 32'(cnt_a));
      xerr = 1'b0;
      if (ifa.out_valid && out_ready) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_beat", 32'(ifa.out_valid), 32'd0);
        end else begin
          e = qa.pop_front();
          chk("a_out_dec", 32'(ifa.out_dec), 32'(e.dec));
          chk("a_out_err", 32'(ifa.out_err), 32'(e.err));
          xerr = e.err;
        end
      end
      cnt_a = cnt_next(cnt_a, clr_err, xerr, 255);
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    beat_t e;
    bit xerr;
    if (rst) begin
      chk("b_rst_out_valid", 32'(ifb.out_valid), 32'd0);
      chk("b_rst_out_dec", 32'(ifb.out_dec), 32'd0);
      chk("b_rst_err_count", 32'(err_count_b), 32'd0);
      qb.delete();
      cnt_b = 0;
    end else begin
      chk("b_err_count", 32'(err_count_b), 32'(cnt_b));
      xerr = 1'b0;
      if (ifb.out_valid && out_ready) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_beat", 32'(ifb.out_valid), 32'd0);
        end else begin
          e = qb.pop_front();
          chk("b_out_dec", 32'(ifb.out_dec), 32'(e.dec[5:0]));
          chk("b_out_err", 32'(ifb.out_err), 32'(e.err));
          xerr = e.err;
        end
      end
      cnt_b = cnt_next(cnt_b, clr_err, xerr, 3);
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("a_ready_after_reset", 32'(ifa.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back one-hot sweep; B flags sel 6 and 7 as out of range.
    for (int s = 0; s < 8; s++) send(s, 0, s == 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_cnt_after_sweep", 32'(err_count_a), 32'd0);
    chk("b_cnt_after_sweep", 32'(err_count_b), 32'd2);

    // Thermometer, active-low and illegal mode.
    send(5, 1, 1'b0);
    send(2, 2, 1'b0);
    send(0, 3, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_cnt_after_modes", 32'(err_count_a), 32'd1);
    chk("b_cnt_after_modes", 32'(err_count_b), 32'd3);

    // Back-pressure: sel 1 to main, sel 2 to skid, sel 3 stalls.
    send(1, 0, 1'b0);
    out_ready = 1'b0;
    send(2, 0, 1'b0);
    in_valid = 1'b1;
    in_sel   = 3'd3;
    in_mode  = 2'd0;
    repeat (3) begin
      @(negedge clk);
      chk("a_bp_in_ready", 32'(ifa.in_ready), 32'd0);
      chk("a_bp_hold_dec", 32'(ifa.out_dec), 32'h02);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3, 0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Five errored beats saturate the 2-bit counter.
    for (int k = 0; k < 5; k++) send(k, 3, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_cnt_five_more", 32'(err_count_a), 32'd6);
    chk("b_cnt_saturated", 32'(err_count_b), 32'd3);

    // Clear coincident with an errored delivery, then clear alone.
    send(0, 3, 1'b0);
    in_valid = 1'b0;
    clr_err  = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    chk("a_clr_with_inc", 32'(err_count_a), 32'd1);
    chk("b_clr_with_inc", 32'(err_count_b), 32'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    chk("a_clr_alone", 32'(err_count_a), 32'd0);
    chk("b_clr_alone", 32'(err_count_b), 32'd0);

    // Randomized traffic with random back-pressure.
    rnd_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      send($urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
    end
    in_valid  = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("a_drained", 32'(qa.size()), 32'd0);
    chk("b_drained", 32'(qb.size()), 32'd0);

    // Fill both entries after an errored delivery, then reset asynchronously.
    send(0, 3, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(1, 0, 1'b0);
    send(2, 0, 1'b0);
    in_valid = 1'b0;
    chk("a_full_in_ready", 32'(ifa.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("a_async_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("a_async_out_dec", 32'(ifa.out_dec), 32'd0);
    chk("a_async_out_err", 32'(ifa.out_err), 32'd0);
    chk("a_async_err_count", 32'(err_count_a), 32'd0);
    chk("b_async_err_count", 32'(err_count_b), 32'd0);
    chk("a_async_in_ready", 32'(ifa.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("a_ready_after_rerst", 32'(ifa.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(4, 1, 1'b1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_final_drained", 32'(qa.size()), 32'd0);
    chk("b_final_drained", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
# onehot_decoder_pipe

Parametrised, registered successor to the 3-to-8 combinational decoder. It decodes an N-bit select into an N_OUT-wide vector in one of three output modes: one-hot, thermometer or active-low one-hot. It adds a valid/ready handshake with a 2-entry skid buffer, out-of-range and illegal-mode detection, and a saturating error counter. It sits between a command producer and banks of enable lines (chip selects, write-enable strobes), where back-pressure from the consumer must not drop or reorder selects.

## Interface
- SEL_W, 3, select width; must be ≥1.
- N_OUT, 8, output width; must satisfy 2 ≤ N_OUT ≤ 2**SEL_W.
- ERR_CNT_W, 8, error counter width.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- in_sel  in  SEL_W  select value.
- in_mode  in  2  00 one-hot, 01 thermometer, 10 active-low one-hot, 11 illegal.
- out_valid  out  1  decoded beat present.
- out_ready  in  1  consumer accepts beat.
- out_dec  out  N_OUT  decoded vector.
- out_err  out  1  beat was out-of-range or illegal mode.
- err_count  out  ERR_CNT_W  saturating count of errored beats delivered.
- clr_err  in  1  synchronous clear of err_count.

## Operation
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Decode is performed on input transfer. Registered results are {out_dec, out_err}.
  - Mode 00: bit in_sel = 1, all other bits 0.
  - Mode 01: bits 0..in_sel = 1, higher bits 0.
  - Mode 10: bitwise inverse of the mode-00 vector.
  - Error case: in_sel ≥ N_OUT, or mode 11. Then out_dec = all zeros in every mode and out_err = 1.
  - Otherwise out_err = 0.
- Storage has two stages:
  - Output register: main, drives out_*.
  - Skid register: holds one beat captured when main is full and not draining.
- in_ready = !skid_valid && !rst (combinational from registered state; no dependency on out_ready).
- State transitions (occupancy 0/1/2):
  - 0 → 1 on input transfer.
  - 1 → 2 on input transfer without output transfer.
  - 1 → 1 on simultaneous transfer: main loads the new beat.
  - 1 → 0 on output transfer only.
  - 2 → 1 on output transfer: skid moves to main. in_ready is 0 in state 2, so no input transfer is possible.
- Beats are delivered in acceptance order. None are dropped or duplicated.
- While out_valid && !out_ready, out_dec and out_err hold stable.
- err_count increments by 1 on each output transfer with out_err = 1, and saturates at 2**ERR_CNT_W−1.
  - clr_err alone clears it to 0.
  - clr_err coincident with an increment loads 1.

## Timing
- Reset (async assert, sync-safe deassert by system): out_valid = 0, out_dec = 0, out_err = 0, err_count = 0, skid empty, in_ready = 0 while rst is high and 1 on the first cycle after.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t; it can be consumed at edge t+1.
- Throughput: 1 beat/cycle sustained with out_ready held high.
- After out_ready drops: at most one further beat is accepted (into skid), then in_ready = 0 from the next cycle.
- Reset mid-operation: all in-flight beats are discarded and the counter is cleared. No output transfer is reported in the reset cycle.
- Mode and select are sampled only on input transfer; changes while in_ready = 0 have no effect.

## Test plan
- Sweep with defaults, mode 00, out_ready = 1, sel 0..7 back-to-back → out_dec = 0x01, 0x02, … 0x80 on consecutive cycles, out_err = 0, latency 1.
- Mode 01 with sel = 5 → 0x3F. Mode 10 with sel = 2 → 0xFB. Mode 11 with sel = 0 → 0x00, out_err = 1, err_count = 1.
- SEL_W = 3, N_OUT = 6, sel = 6 and sel = 7 in mode 00 → 0x00 with out_err = 1 each. err_count = 2 after both are delivered. sel = 5 → 0x20, out_err = 0.
- Back-pressure: stream sel 1, 2, 3 with out_ready low from the cycle after the first acceptance.
  - Required: in_ready = 0 after two beats held, out_dec holds 0x02.
  - Raise out_ready: outputs 0x02, 0x04, 0x08 follow in order, nothing lost.
- Counter: ERR_CNT_W = 2 with 5 errored beats → err_count saturates at 3. Assert clr_err in the same cycle as a 6th errored output transfer → err_count = 1. Then clr_err alone → 0.
- Assert rst asynchronously with both entries full → out_valid, out_dec, out_err and err_count are 0 immediately, in_ready = 0. After release, in_ready = 1 and the first new beat emerges 1 cycle after acceptance.
